pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/flow controller that drives the team's 16-bit load-or-increment program counter through its load/datain inputs. It issues instruction-fetch requests at the counter's current value and presents the fetched word to the decoder. It applies the decoder's flow op (next, jump, call, return, halt) and keeps a small return-address stack. The controller and the counter sit side by side at CPU top level; the counter's async reset is tied to ~reset_n there.

Parameters:
WIDTH, 16, address/instruction width; must match the counter.
RESET_VECTOR, 16'h0000, first fetch address after reset.
STACK_DEPTH, 4, return-stack entries; power of 2, ≥2.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
pc_value  in  WIDTH  counter dataout
pc_load  out  1  counter load
pc_datain  out  WIDTH  counter datain
imem_req  out  1  fetch request
imem_addr  out  WIDTH  fetch address (= pc_value)
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  WIDTH  fetched word
ir  out  WIDTH  instruction register
ir_valid  out  1  ir presented to decoder
ctl_valid  in  1  decoder flow op valid
ctl_ready  out  1  op accepted when ctl_valid&ctl_ready
ctl_op  in  3  000 NEXT, 001 JUMP, 010 CALL, 011 RET, 100 HALT, others reserved
ctl_target  in  WIDTH  JUMP/CALL target
resume  in  1  leave HALTED
halted  out  1  in HALTED
stack_err  out  1  sticky error, cleared on resume
sp_level  out  $clog2(STACK_DEPTH)+1  stack occupancy

Behaviour:
- Hold rule: the counter increments whenever load=0, so every cycle that must not advance the PC drives pc_load=1, pc_datain=pc_value.
- States: BOOT, FETCH, DECODE, HALTED. Moore outputs from state; ctl path is Mealy in DECODE.
- Reset (async, reset_n=0): state=BOOT, ir=0, stack and sp_level=0, stack_err=0. Outputs: pc_load=1, pc_datain=RESET_VECTOR, imem_req=0, ir_valid=0, ctl_ready=0, halted=0.
- BOOT: load RESET_VECTOR for one cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=pc_value, PC held. imem_ack may arrive in the first request cycle. On ack: ir<=imem_data, -> DECODE. Without ack, address stays stable.
- DECODE: ir_valid=1, ctl_ready=1. PC held until ctl_valid. On accept:
  NEXT: pc_load=0, so the counter increments; 0xFFFF wraps to 0x0000. -> FETCH.
  JUMP: load ctl_target -> FETCH.
  CALL: push pc_value+1 (mod 2^WIDTH), load ctl_target -> FETCH. If the stack is full: no push, PC held, stack_err=1 -> HALTED.
  RET: pop, load popped value -> FETCH. If the stack is empty: PC held, stack_err=1 -> HALTED.
  HALT: PC held -> HALTED.
  Reserved: as HALT, plus stack_err=1.
- HALTED: halted=1, PC held, ctl_ready=0. resume=1 -> FETCH and clears stack_err; the stack is retained. resume is ignored in other states. ctl_valid outside DECODE is ignored.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ack, then DECODE with immediate ctl_valid).
- Reset mid-operation: all outputs revert immediately (async). An in-flight fetch is abandoned and imem_req drops without waiting for ack.

Decomposition:
- Shared package: ctl_op encodings (OP_NEXT..OP_HALT), state enum, WIDTH default.
- One sub-module, pc_return_stack: LIFO with push/pop/full/empty/level and async active-low reset. Push and pop never occur in the same cycle.

Test Plan:
1. RESET_VECTOR=0x0100; release reset_n -> 1st edge: pc_load=1, pc_datain=0x0100. Next cycle: imem_req=1, imem_addr=0x0100.
2. Ack delayed 2 cycles, then NEXT -> pc_load=1/datain=0x0100 throughout the wait; ir=ack data; next fetch at 0x0101.
3. JUMP 0x2000 from 0x0101 -> next imem_addr=0x2000, sp_level unchanged.
4. CALL 0x3000 at 0x0105, NEXT, RET -> fetches 0x3000, 0x3001, then 0x0106; sp_level goes 1 then 0.
5. Five nested CALLs, depth 4 -> 5th: halted=1, stack_err=1, PC held at the 5th call's address, sp_level=4. resume -> refetch that address, stack_err=0.
6. Pair: RET with empty stack -> halted=1, stack_err=1. NEXT at 0xFFFF -> fetch 0x0000. reset_n low mid-FETCH -> imem_req=0 immediately, sp_level=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/flow controller.
// Holds the flow-op encodings, the controller state enum and the default
// address/instruction width.
package pc_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned OP_W      = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT = 3'b000,
    OP_JUMP = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011,
    OP_HALT = 3'b100
  } ctl_op_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch and decoder handshake bundle between the sequencer and its neighbours.
//   imem_req/imem_addr -> fetch request;  imem_ack/imem_data <- fetch response
//   ir/ir_valid        -> instruction presented to the decoder
//   ctl_valid/ctl_op/ctl_target <- decoder flow op;  ctl_ready -> op accepted
// master: the sequencer; slave: memory + decoder side.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_data;
  logic [WIDTH-1:0] ir;
  logic             ir_valid;
  logic             ctl_valid;
  logic             ctl_ready;
  logic [OP_W-1:0]  ctl_op;
  logic [WIDTH-1:0] ctl_target;

  modport master (
    output imem_req, imem_addr, ir, ir_valid, ctl_ready,
    input  imem_ack, imem_data, ctl_valid, ctl_op, ctl_target
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, ctl_ready,
    output imem_ack, imem_data, ctl_valid, ctl_op, ctl_target
  );

endinterface

// File: rtl/pc_return_stack.sv
// Return-address LIFO.
//   push/push_data : store a word (ignored when full)
//   pop            : drop the top word (ignored when empty)
//   top            : current top-of-stack word
//   full/empty/level : occupancy
// Push and pop are never asserted together by the sequencer.
module pc_return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       top,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Level doubles as the write pointer; top sits one below it.
  assign wr_idx = IDX_W'(level_q);
  assign rd_idx = IDX_W'(level_q - LVL_W'(1));

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign top   = mem_q[rd_idx];

  // Storage and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !full) begin
      mem_q[wr_idx] <= push_data;
      level_q       <= level_q + LVL_W'(1);
    end else if (pop && !empty) begin
      level_q <= level_q - LVL_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/flow controller driving an external load-or-increment PC counter.
//   clk, reset_n      : clock, async active-low reset
//   pc_value          : counter output
//   pc_load/pc_datain : counter controls (counter increments when pc_load=0)
//   bus               : fetch + decoder handshakes (master side)
//   resume            : leave HALTED
//   halted, stack_err, sp_level : status
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     WIDTH        = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STACK_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             pc_value,
  output logic                         pc_load,
  output logic [WIDTH-1:0]             pc_datain,
  pc_sequencer_if.master               bus,
  input  logic                         resume,
  output logic                         halted,
  output logic                         stack_err,
  output logic [$clog2(STACK_DEPTH):0] sp_level
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] ir_q;
  logic             ir_load;
  logic             err_set;
  logic             err_clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full;
  logic             stk_empty;
  logic             imem_req;
  logic             ir_valid;
  logic             ctl_ready;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_value + WIDTH'(1)),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .level     (sp_level)
  );

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc_value;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid;
  assign bus.ctl_ready = ctl_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register and sticky stack error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q      <= '0;
      stack_err <= 1'b0;
    end else begin
      if (ir_load) begin
        ir_q <= bus.imem_data;
      end
      if (err_set) begin
        stack_err <= 1'b1;
      end else if (err_clr) begin
        stack_err <= 1'b0;
      end
    end
  end

  // Next state and outputs; the counter is held (reloaded with itself)
  // on every cycle that must not advance it.
  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b1;
    pc_datain = pc_value;
    imem_req  = 1'b0;
    ir_valid  = 1'b0;
    ctl_ready = 1'b0;
    halted    = 1'b0;
    ir_load   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_datain = RESET_VECTOR;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ir_valid  = 1'b1;
        ctl_ready = 1'b1;
        if (bus.ctl_valid) begin
          case (bus.ctl_op)
            OP_NEXT: begin
              pc_load = 1'b0;
              state_d = ST_FETCH;
            end
            OP_JUMP: begin
              pc_datain = bus.ctl_target;
              state_d   = ST_FETCH;
            end
            OP_CALL: begin
              if (stk_full) begin
                err_set = 1'b1;
                state_d = ST_HALTED;
              end else begin
                push      = 1'b1;
                pc_datain = bus.ctl_target;
                state_d   = ST_FETCH;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                err_set = 1'b1;
                state_d = ST_HALTED;
              end else begin
                pop       = 1'b1;
                pc_datain = stk_top;
                state_d   = ST_FETCH;
              end
            end
            OP_HALT: begin
              state_d = ST_HALTED;
            end
            default: begin
              err_set = 1'b1;
              state_d = ST_HALTED;
            end
          endcase
        end
      end

      ST_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          err_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = 16'h0100;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  pc_value;
  logic          pc_load;
  logic [W-1:0]  pc_datain;
  logic          resume;
  logic          halted;
  logic          stack_err;
  logic [2:0]    sp_level;

  int            checks;
  int            failures;
  logic [W-1:0]  fetch_q[$];
  logic [W-1:0]  model_stk[$];
  logic [W-1:0]  exp_pc;
  logic          exp_err;

  pc_sequencer_if #(.WIDTH(W)) bus ();

  pc_sequencer #(
    .WIDTH        (W),
    .RESET_VECTOR (RV),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc_value  (pc_value),
    .pc_load   (pc_load),
    .pc_datain (pc_datain),
    .bus       (bus),
    .resume    (resume),
    .halted    (halted),
    .stack_err (stack_err),
    .sp_level  (sp_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load-or-increment counter sitting beside the sequencer.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pc_value <= '0;
    else if (pc_load) pc_value <= pc_datain;
    else              pc_value <= pc_value + 16'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for a fetch, compare its address with the scoreboard, ack after dly cycles.
  task automatic do_fetch(input int dly);
    logic [W-1:0] data;
    for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("fetch_req", 32'(bus.imem_req), 32'd1);
    if (fetch_q.size() == 0) begin
      check("sb_underflow", 32'(fetch_q.size()), 32'd1);
      exp_pc = pc_value;
    end else begin
      exp_pc = fetch_q.pop_front();
    end
    check("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
    for (int i = 0; i < dly; i++) begin
      check("wait_load", 32'(pc_load), 32'd1);
      check("wait_datain", 32'(pc_datain), 32'(exp_pc));
      @(posedge clk); #1;
      check("wait_addr", 32'(bus.imem_addr), 32'(exp_pc));
    end
    data = exp_pc ^ 16'hA5C3;
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    @(posedge clk); #1;
    bus.imem_ack  = 1'b0;
    check("ir", 32'(bus.ir), 32'(data));
    check("ir_valid", 32'(bus.ir_valid), 32'd1);
  endtask

  // Issue one flow op in DECODE and predict its effect.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] tgt);
    logic         exp_load;
    logic [W-1:0] exp_din;
    logic         exp_halt;
    exp_load = 1'b1;
    exp_din  = exp_pc;
    exp_halt = 1'b0;
    case (op)
      OP_NEXT: begin
        exp_load = 1'b0;
        fetch_q.push_back(exp_pc + 16'd1);
      end
      OP_JUMP: begin
        exp_din = tgt;
        fetch_q.push_back(tgt);
      end
      OP_CALL: begin
        if (model_stk.size() < DEPTH) begin
          model_stk.push_back(exp_pc + 16'd1);
          exp_din = tgt;
          fetch_q.push_back(tgt);
        end else begin
          exp_halt = 1'b1;
          exp_err  = 1'b1;
        end
      end
      OP_RET: begin
        if (model_stk.size() > 0) begin
          exp_din = model_stk.pop_back();
          fetch_q.push_back(exp_din);
        end else begin
          exp_halt = 1'b1;
          exp_err  = 1'b1;
        end
      end
      OP_HALT: exp_halt = 1'b1;
      default: begin
        exp_halt = 1'b1;
        exp_err  = 1'b1;
      end
    endcase
    check("ctl_ready", 32'(bus.ctl_ready), 32'd1);
    bus.ctl_valid  = 1'b1;
    bus.ctl_op     = op;
    bus.ctl_target = tgt;
    #1;
    check("op_load", 32'(pc_load), 32'(exp_load));
    if (exp_load) check("op_datain", 32'(pc_datain), 32'(exp_din));
    @(posedge clk); #1;
    bus.ctl_valid = 1'b0;
    check("halted", 32'(halted), 32'(exp_halt));
    check("stack_err", 32'(stack_err), 32'(exp_err));
    check("sp_level", 32'(sp_level), 32'(model_stk.size()));
    if (exp_halt) begin
      check("halt_ready", 32'(bus.ctl_ready), 32'd0);
      check("halt_req", 32'(bus.imem_req), 32'd0);
      @(posedge clk); #1;
      check("halt_pc", 32'(pc_value), 32'(exp_pc));
    end
  endtask

  task automatic do_resume();
    resume = 1'b1;
    @(posedge clk); #1;
    resume  = 1'b0;
    exp_err = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_err", 32'(stack_err), 32'd0);
    fetch_q.push_back(exp_pc);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    exp_err        = 1'b0;
    exp_pc         = '0;
    reset_n        = 1'b0;
    resume         = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_data  = '0;
    bus.ctl_valid  = 1'b0;
    bus.ctl_op     = '0;
    bus.ctl_target = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_load", 32'(pc_load), 32'd1);
    check("rst_datain", 32'(pc_datain), 32'(RV));
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_ready", 32'(bus.ctl_ready), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(stack_err), 32'd0);
    check("rst_sp", 32'(sp_level), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("boot_load", 32'(pc_load), 32'd1);
    check("boot_datain", 32'(pc_datain), 32'(RV));
    fetch_q.push_back(RV);
    @(posedge clk); #1;

    // Delayed ack, NEXT, JUMP.
    do_fetch(2);
    do_op(OP_NEXT, '0);
    do_fetch(0);
    do_op(OP_JUMP, 16'h2000);
    do_fetch(0);
    do_op(OP_JUMP, 16'h0105);

    // CALL / NEXT / RET.
    do_fetch(0);
    do_op(OP_CALL, 16'h3000);
    do_fetch(0);
    do_op(OP_NEXT, '0);
    do_fetch(1);
    do_op(OP_RET, '0);

    // Nested calls overflow the stack on the fifth.
    do_fetch(0);
    for (int i = 0; i < 5; i++) begin
      do_op(OP_CALL, 16'h4000 + 16'(i * 16'h0100));
      if (i < 4) do_fetch(0);
    end
    do_resume();
    do_fetch(0);

    // Unwind, then RET on empty stack.
    for (int i = 0; i < 4; i++) begin
      do_op(OP_RET, '0);
      do_fetch(0);
    end
    do_op(OP_RET, '0);
    do_resume();
    do_fetch(0);

    // Reserved op halts with error; plain HALT halts without.
    do_op(3'b111, '0);
    do_resume();
    do_fetch(0);
    do_op(OP_HALT, '0);
    do_resume();
    do_fetch(0);

    // Wrap from 0xFFFF.
    do_op(OP_JUMP, 16'hFFFF);
    do_fetch(0);
    do_op(OP_NEXT, '0);
    do_fetch(0);
    do_op(OP_CALL, 16'h5000);

    // Async reset mid-fetch.
    for (int i = 0; i < 5 && bus.imem_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_req", 32'(bus.imem_req), 32'd1);
    check("pre_rst_sp", 32'(sp_level), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check("mid_rst_sp", 32'(sp_level), 32'd0);
    check("mid_rst_load", 32'(pc_load), 32'd1);
    check("mid_rst_datain", 32'(pc_datain), 32'(RV));
    check("mid_rst_ir", 32'(bus.ir), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
